// File: rtl/div_iter_ctrl.sv
// div_iter_ctrl: iterative signed restoring divider with its own datapath.
// It retires one quotient bit per clock over WIDTH iterations, then does a
// sign-fixup cycle and pulses data_resultRDY for one cycle.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous active-high reset (clears all state and outputs)
//   ctrl_DIV       start strobe; restarts the divider from any state
//   data_operandA  dividend, two's complement
//   data_operandB  divisor, two's complement
//   data_result    signed quotient, truncated toward zero
//   data_remainder signed remainder, sign follows the dividend
//   data_exception divide-by-zero flag
//   data_resultRDY one-cycle result-valid pulse
//   busy           high while iterating or fixing up signs
module div_iter_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e           state_q, state_d;
    logic             sign_quo_q, sign_quo_d;
    logic             sign_rem_q, sign_rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             exc_q, exc_d;

    // Magnitudes as unsigned WIDTH-bit values; the most negative input maps to 2^(WIDTH-1).
    logic [WIDTH-1:0] abs_a, abs_b;
    assign abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

    // Partial remainder after the left shift, and the WIDTH+1 bit trial subtract.
    // The remainder MSB is always 0 here because R < |B| <= 2^(WIDTH-1).
    logic [WIDTH-1:0] shifted_r;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    assign shifted_r = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign trial     = {1'b0, shifted_r} - {1'b0, div_q};
    assign trial_ok  = ~trial[WIDTH];

    always_comb begin
        state_d     = state_q;
        sign_quo_d  = sign_quo_q;
        sign_rem_d  = sign_rem_q;
        div_d       = div_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exc_d       = exc_q;

        if (ctrl_DIV) begin
            // A strobe in any state aborts whatever is in flight and restarts.
            if (data_operandB == '0) begin
                result_d    = '0;
                remainder_d = '0;
                exc_d       = 1'b1;
                state_d     = StDone;
            end else begin
                sign_quo_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                sign_rem_d = data_operandA[WIDTH-1];
                div_d      = abs_b;
                rem_d      = '0;
                quo_d      = abs_a;
                cnt_d      = '0;
                state_d    = StRun;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StRun: begin
                    rem_d = trial_ok ? trial[WIDTH-1:0] : shifted_r;
                    quo_d = {quo_q[WIDTH-2:0], trial_ok};
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    // Negation wraps, so MIN / -1 yields MIN.
                    result_d    = sign_quo_q ? (~quo_q + 1'b1) : quo_q;
                    remainder_d = sign_rem_q ? (~rem_q + 1'b1) : rem_q;
                    exc_d       = 1'b0;
                    state_d     = StDone;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            sign_quo_q  <= 1'b0;
            sign_rem_q  <= 1'b0;
            div_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_quo_q  <= sign_quo_d;
            sign_rem_q  <= sign_rem_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exc_q       <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == StDone);
    assign busy           = (state_q == StRun) || (state_q == StFix);

endmodule

// File: tb/tb_div_iter_ctrl.sv
// Scoreboard bench for div_iter_ctrl: stimulus pushes the expected outcome of
// each division (computed with 64-bit arithmetic), a monitor pops it on RDY.
module tb_div_iter_ctrl;

    localparam int W = 32;

    logic          clock;
    logic          reset;
    logic          ctrl_DIV;
    logic [W-1:0]  data_operandA;
    logic [W-1:0]  data_operandB;
    logic [W-1:0]  data_result;
    logic [W-1:0]  data_remainder;
    logic          data_exception;
    logic          data_resultRDY;
    logic          busy;

    div_iter_ctrl #(.WIDTH(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_remainder(data_remainder),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         exc;
        int           rdy_cyc;
        int           busy_n;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   busy_run = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: signed division in 64-bit arithmetic truncates toward zero,
    // and taking the low W bits gives the wrapped result for MIN / -1.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int c0);
        exp_t   e;
        longint la;
        longint lb;
        longint lq;
        longint lr;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (b == '0) begin
            e.q       = '0;
            e.r       = '0;
            e.exc     = 1'b1;
            e.rdy_cyc = c0;
            e.busy_n  = 0;
        end else begin
            lq        = la / lb;
            lr        = la % lb;
            e.q       = lq[W-1:0];
            e.r       = lr[W-1:0];
            e.exc     = 1'b0;
            e.rdy_cyc = c0 + W + 1;
            e.busy_n  = W + 1;
        end
        return e;
    endfunction

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        busy_run = 0;
        e = model(a, b, cyc);
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rdy_timeout actual=pending%0d required=pending0", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (busy) busy_run++;
            if (data_resultRDY && busy) chk("rdy_and_busy", 32'd1, 32'd0);
            if (data_resultRDY) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rdy", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result", data_result, e.q);
                    chk("remainder", data_remainder, e.r);
                    chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
                    chk("rdy_cycle", cyc, e.rdy_cyc);
                    chk("busy_cycles", busy_run, e.busy_n);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("rst_result", data_result, 32'd0);
        chk("rst_exc", {31'd0, data_exception}, 32'd0);

        start(32'd100, 32'd7);            wait_done();
        start(-32'sd100, 32'd7);          wait_done();
        start(32'd100, -32'sd7);          wait_done();
        start(32'd7, 32'd0);              wait_done();
        start(32'd9, 32'd3);              wait_done();
        start(32'h8000_0000, 32'hFFFF_FFFF); wait_done();
        start(32'h8000_0000, 32'd1);      wait_done();

        // Abort at iteration 10: only the second operation may report.
        start(32'd50, 32'd5);
        repeat (10) @(posedge clock);
        void'(sb.pop_back());
        start(32'd81, 32'd9);
        wait_done();
        repeat (40) @(negedge clock);

        // Reset mid-operation clears everything and suppresses RDY.
        start(32'd1000, 32'd3);
        repeat (20) @(posedge clock);
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("midrst_result", data_result, 32'd0);
        chk("midrst_remainder", data_remainder, 32'd0);
        chk("midrst_exc", {31'd0, data_exception}, 32'd0);
        repeat (40) @(negedge clock);

        start(32'hFFFF_FFFF, 32'd2);      wait_done();

        for (int n = 0; n < 50; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 200) - 100;
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       b = 32'hFFFF_FFFF;
                2, 3, 4: b = $urandom_range(0, 40) - 20;
                5:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            start(a, b);
            wait_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
